// File: rtl/mc_controller_if.sv
// mc_controller_if: control bundle between the multicycle controller
// and its datapath / memory side.
interface mc_controller_if;
  logic [6:0] Opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       Branch;
  logic       JalrSel;
  logic       IorD;
  logic [1:0] ALUOp;
  logic       illegal;
  logic       bus_err;
  logic [2:0] state;

  modport master (
    input  Opcode,
    input  mem_ready,
    output PCWrite,
    output IRWrite,
    output MemRead,
    output MemWrite,
    output RegWrite,
    output ALUSrc,
    output MemtoReg,
    output Branch,
    output JalrSel,
    output IorD,
    output ALUOp,
    output illegal,
    output bus_err,
    output state
  );

  modport slave (
    output Opcode,
    output mem_ready,
    input  PCWrite,
    input  IRWrite,
    input  MemRead,
    input  MemWrite,
    input  RegWrite,
    input  ALUSrc,
    input  MemtoReg,
    input  Branch,
    input  JalrSel,
    input  IorD,
    input  ALUOp,
    input  illegal,
    input  bus_err,
    input  state
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32 subset control FSM with memory wait
// timeout. Optional JAL/JALR support is enabled by macro MC_JUMP_EN.
module mc_controller #(
  parameter int WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          reset,
  mc_controller_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_BRANCH = 3'd5;
`ifdef MC_JUMP_EN
  localparam logic [2:0] S_JUMP   = 3'd6;
`endif

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
`ifdef MC_JUMP_EN
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
`endif

  localparam logic [7:0] LP_WMAX = 8'(WAIT_MAX);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [6:0] r_op_q;
  logic [7:0] r_wait;

  logic w_mem_phase;
  logic w_mem_wait;
  logic w_timeout;

  logic w_d_exec;
  logic w_d_beq;
  logic w_d_jump;
  logic w_d_legal;

  logic w_q_r;
  logic w_q_i;
  logic w_q_lui;
  logic w_q_lw;
  logic w_q_sw;
  logic w_q_jalr;

  logic       w_pcwrite;
  logic       w_irwrite;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_alusrc;
  logic       w_memtoreg;
  logic       w_branch;
  logic       w_jalrsel;
  logic       w_iord;
  logic [1:0] w_aluop;
  logic       w_illegal;
  logic       w_bus_err;

  // Opcode presented during DECODE, classified for the branch decision.
  assign w_d_exec  = (bus.Opcode == OP_R)  |
                     (bus.Opcode == OP_I)  |
                     (bus.Opcode == OP_LUI)|
                     (bus.Opcode == OP_LW) |
                     (bus.Opcode == OP_SW);
  assign w_d_beq   = (bus.Opcode == OP_BEQ);
`ifdef MC_JUMP_EN
  assign w_d_jump  = (bus.Opcode == OP_JAL) |
                     (bus.Opcode == OP_JALR);
`else
  assign w_d_jump  = 1'b0;
`endif
  assign w_d_legal = w_d_exec | w_d_beq | w_d_jump;

  // Registered opcode drives every post-DECODE decision.
  assign w_q_r    = (r_op_q == OP_R);
  assign w_q_i    = (r_op_q == OP_I);
  assign w_q_lui  = (r_op_q == OP_LUI);
  assign w_q_lw   = (r_op_q == OP_LW);
  assign w_q_sw   = (r_op_q == OP_SW);
`ifdef MC_JUMP_EN
  assign w_q_jalr = (r_op_q == OP_JALR);
`else
  assign w_q_jalr = 1'b0;
`endif

  // Only FETCH and MEM look at mem_ready; a stall there counts toward
  // the timeout, and hitting the limit without ready aborts the access.
  assign w_mem_phase = (r_state == S_FETCH) | (r_state == S_MEM);
  assign w_mem_wait  = w_mem_phase & ~bus.mem_ready;
  assign w_timeout   = w_mem_wait & (r_wait == LP_WMAX);

  // State register; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Opcode capture in DECODE.
  always_ff @(posedge clk) begin
    if (reset)                  r_op_q <= 7'd0;
    else if (r_state == S_DECODE) r_op_q <= bus.Opcode;
  end

  // Wait counter: cleared on any transition or timeout, counts stalls.
  always_ff @(posedge clk) begin
    if (reset)
      r_wait <= 8'd0;
    else if ((w_next != r_state) | w_timeout)
      r_wait <= 8'd0;
    else if (w_mem_wait)
      r_wait <= r_wait + 8'd1;
  end

  // Next-state decision.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) w_next = S_DECODE;
        else               w_next = S_FETCH;
      end
      S_DECODE: begin
        unique case (1'b1)
          w_d_exec: w_next = S_EXEC;
          w_d_beq:  w_next = S_BRANCH;
`ifdef MC_JUMP_EN
          w_d_jump: w_next = S_JUMP;
`endif
          default:  w_next = S_FETCH;
        endcase
      end
      S_EXEC: begin
        if (w_q_r | w_q_i | w_q_lui)  w_next = S_WB;
        else if (w_q_lw | w_q_sw)     w_next = S_MEM;
        else                          w_next = S_FETCH;
      end
      S_MEM: begin
        if (bus.mem_ready)
          w_next = w_q_lw ? S_WB : S_FETCH;
        else if (w_timeout)
          w_next = S_FETCH;
        else
          w_next = S_MEM;
      end
      S_WB:     w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
`ifdef MC_JUMP_EN
      S_JUMP:   w_next = S_FETCH;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  // Output decode; everything reads zero while reset is held.
  always_comb begin
    w_pcwrite  = 1'b0;
    w_irwrite  = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_alusrc   = 1'b0;
    w_memtoreg = 1'b0;
    w_branch   = 1'b0;
    w_jalrsel  = 1'b0;
    w_iord     = 1'b0;
    w_aluop    = 2'b00;
    w_illegal  = 1'b0;
    w_bus_err  = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          w_memread = ~w_timeout;
          w_bus_err = w_timeout;
          w_irwrite = bus.mem_ready;
          w_pcwrite = bus.mem_ready;
        end
        S_DECODE: begin
          w_illegal = ~w_d_legal;
        end
        S_EXEC: begin
          w_alusrc = w_q_i | w_q_lui | w_q_lw | w_q_sw;
          unique case (1'b1)
            w_q_lui:         w_aluop = 2'b11;
            (w_q_r | w_q_i): w_aluop = 2'b10;
            default:         w_aluop = 2'b00;
          endcase
        end
        S_MEM: begin
          w_iord     = 1'b1;
          w_alusrc   = 1'b1;
          w_memread  = w_q_lw & ~w_timeout;
          w_memwrite = w_q_sw & ~w_timeout;
          w_bus_err  = w_timeout;
        end
        S_WB: begin
          w_regwrite = 1'b1;
          w_memtoreg = w_q_lw;
        end
        S_BRANCH: begin
          w_branch = 1'b1;
          w_aluop  = 2'b01;
        end
`ifdef MC_JUMP_EN
        S_JUMP: begin
          w_regwrite = 1'b1;
          w_pcwrite  = 1'b1;
          w_jalrsel  = w_q_jalr;
        end
`endif
        default: begin
          w_pcwrite = 1'b0;
        end
      endcase
    end
  end

  assign bus.PCWrite  = w_pcwrite;
  assign bus.IRWrite  = w_irwrite;
  assign bus.MemRead  = w_memread;
  assign bus.MemWrite = w_memwrite;
  assign bus.RegWrite = w_regwrite;
  assign bus.ALUSrc   = w_alusrc;
  assign bus.MemtoReg = w_memtoreg;
  assign bus.Branch   = w_branch;
  assign bus.JalrSel  = w_jalrsel;
  assign bus.IorD     = w_iord;
  assign bus.ALUOp    = w_aluop;
  assign bus.illegal  = w_illegal;
  assign bus.bus_err  = w_bus_err;
  assign bus.state    = reset ? S_FETCH : r_state;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter WAIT_MAX, default 15, is the maximum number of memory wait cycles tolerated before a bus error is declared (legal range 1..255).
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port Opcode, input, 7 bits: opcode field taken from the instruction register; valid only in DECODE.
REQ-005 Port mem_ready, input, 1 bit: the shared memory completes the current access this cycle.
REQ-006 Outputs PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrc, MemtoReg, Branch, JalrSel and IorD are each 1 bit (IorD: 0 = PC address, 1 = ALU address).
REQ-007 Port ALUOp, output, 2 bits: 00 = load/store, 01 = branch, 10 = R/I type, 11 = LUI.
REQ-008 Port illegal, output, 1 bit: one-cycle pulse when an unsupported opcode is decoded.
REQ-009 Port bus_err, output, 1 bit: one-cycle pulse on a memory wait timeout.
REQ-010 Port state, output, 3 bits: the current FSM state encoding, for debug.

Function
REQ-011 The FSM states and encodings shall be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, JUMP=6; encoding 7 is unreachable and shall return to FETCH.
REQ-012 All outputs shall be decoded combinationally from state, the registered opcode op_q, and mem_ready; every output not asserted in a state shall be 0.
REQ-013 FETCH: assert MemRead with IorD=0; when mem_ready=1, pulse IRWrite and PCWrite in that same cycle and go to DECODE; otherwise stay in FETCH.
REQ-014 DECODE: capture Opcode into op_q.
- R (0110011), I (0010011), LUI (0110111), LW (0000011), SW (0100011) go to EXEC.
- BEQ (1100011) goes to BRANCH.
- JAL (1101111) and JALR (1100111) are handled per REQ-026.
- Any other opcode pulses illegal and goes to FETCH.
REQ-015 EXEC: ALUSrc=1 for I, LUI, LW and SW; ALUOp per REQ-007. R, I and LUI go to WB; LW and SW go to MEM.
REQ-016 MEM: assert IorD=1, ALUSrc=1 and ALUOp=00, plus MemRead for LW or MemWrite for SW. On mem_ready, SW goes to FETCH and LW goes to WB.
REQ-017 WB: assert RegWrite, with MemtoReg=1 only for LW; then go to FETCH.
REQ-018 BRANCH: assert Branch with ALUOp=01; then go to FETCH.
REQ-019 Instruction latency with zero wait states shall be: R/I/LUI 4 cycles, SW 4, LW 5, BEQ 3, JAL/JALR 3, illegal 2.
REQ-020 An 8-bit wait counter shall clear on every state transition and increment on each FETCH or MEM cycle that has mem_ready=0.
REQ-021 When the wait counter equals WAIT_MAX and mem_ready=0, the block shall pulse bus_err, drop MemRead/MemWrite in that cycle, and go to FETCH without asserting IRWrite, PCWrite or RegWrite.
REQ-022 If mem_ready=1 in the same cycle the counter reaches WAIT_MAX, the access completes normally and bus_err stays 0.
REQ-023 mem_ready shall be ignored in every state other than FETCH and MEM.

Reset
REQ-024 While reset=1 at a clock edge: state becomes FETCH, op_q becomes 0000000, and the wait counter becomes 0, overriding any transition including one from mid-MEM or mid-wait.
REQ-025 While reset=1 every output except state shall read 0, and state shall read 0; normal operation starts on the first edge after reset is released.

Configuration
REQ-026 Macro MC_JUMP_EN:
- When defined, JAL and JALR go to JUMP, which asserts RegWrite and PCWrite with JalrSel=1 for JALR only, then goes to FETCH.
- When undefined, JUMP is not implemented, JAL and JALR are treated as illegal, and JalrSel is tied to 0.

Verification
REQ-027 After reset, ADDI with mem_ready always 1 -> states 0,1,2,4; ALUSrc=1 in EXEC; RegWrite=1 only in WB; back in FETCH on cycle 5.
REQ-028 LW with mem_ready held low for 2 MEM cycles -> MEM lasts 3 cycles with MemRead=1 and IorD=1 throughout; then WB with MemtoReg=1; total 7 cycles.
REQ-029 WAIT_MAX=3 with mem_ready stuck at 0 in FETCH -> bus_err pulses on the 4th FETCH cycle; IRWrite never asserts; state stays 0.
REQ-030 Opcode 1111111 in DECODE -> illegal=1 for exactly one cycle; next state 0; no RegWrite, MemWrite or PCWrite.
REQ-031 JALR with MC_JUMP_EN defined -> JUMP with JalrSel=1, RegWrite=1, PCWrite=1; with it undefined -> illegal pulse and return to FETCH.
REQ-032 Assert reset during a SW MEM wait -> MemWrite=0 in the reset cycle; state=0 after the edge; no write completes.
